// File: rtl/top.sv
// Instruction-driven signed 8-bit matrix multiply. The A, B and result buffers are host-accessible.
// A row of 16 MAC lanes produces one output row every K cycles.
module top (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr_A,
    input  logic        en_A,
    input  logic [15:0] data_A,
    input  logic [7:0]  addr_B,
    input  logic        en_B,
    input  logic [15:0] data_B,
    input  logic [7:0]  addr_I,
    input  logic        en_I,
    input  logic [5:0]  data_I,
    input  logic [7:0]  addr_O,
    input  logic        en_O,
    output logic [15:0] data_O,
    output logic        out_valid,
    input  logic        ap_start,
    output logic        ap_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

    state_t             state_r;
    logic [15:0]        a_mem_r   [64];
    logic [15:0]        b_mem_r   [64];
    logic [15:0]        res_mem_r [256];
    logic [5:0]         inst_r;
    logic [4:0]         cfg_m_r;
    logic [4:0]         cfg_n_r;
    logic [3:0]         cfg_k_r;
    logic [3:0]         row_r;
    logic [2:0]         k_r;
    logic signed [15:0] acc_r      [16];
    logic signed [15:0] acc_next_s [16];
    logic signed [15:0] prod_s     [16];
    logic signed [7:0]  b_val_s    [16];
    logic [6:0]         b_idx_s    [16];
    logic [7:0]         res_idx_s  [16];
    logic signed [7:0]  a_val_s;
    logic [6:0]         a_idx_s;
    logic [8:0]         mn_s;
    logic               row_end_s;
    logic               last_row_s;
    logic               unused_s;

    function automatic logic signed [7:0] pick_byte(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [4:0] dim4(input logic [1:0] f);
        return {1'b0, f, 2'b00} + 5'd4;
    endfunction

    function automatic logic [3:0] dim2(input logic [1:0] f);
        return {1'b0, f, 1'b0} + 4'd2;
    endfunction

    assign unused_s = ^{addr_I, addr_A[7:6], addr_B[7:6]};

    // Legal result range follows the instruction register as it currently stands
    always_comb begin
        mn_s = 9'(dim4(inst_r[5:4])) * 9'(dim4(inst_r[1:0]));
    end

    // MAC lanes: lane c accumulates A[row][k] * B[k][c]; k==0 starts a fresh sum
    always_comb begin
        a_idx_s    = {3'b000, row_r} * {3'b000, cfg_k_r} + {4'b0000, k_r};
        a_val_s    = pick_byte(a_mem_r[a_idx_s[6:1]], a_idx_s[0]);
        row_end_s  = ({1'b0, k_r} == (cfg_k_r - 4'd1));
        last_row_s = ({1'b0, row_r} == (cfg_m_r - 5'd1));
        for (int c = 0; c < 16; c++) begin
            b_idx_s[c]    = {4'b0000, k_r} * {2'b00, cfg_n_r} + 7'(c);
            b_val_s[c]    = pick_byte(b_mem_r[b_idx_s[c][6:1]], b_idx_s[c][0]);
            prod_s[c]     = 16'(a_val_s) * 16'(b_val_s[c]);
            acc_next_s[c] = ((k_r == 3'd0) ? 16'sd0 : acc_r[c]) + prod_s[c];
            res_idx_s[c]  = {4'b0000, row_r} * {3'b000, cfg_n_r} + 8'(c);
        end
    end

    // A operand buffer (not reset)
    always_ff @(posedge clk) begin
        if (en_A) a_mem_r[addr_A[5:0]] <= data_A;
    end

    // B operand buffer (not reset)
    always_ff @(posedge clk) begin
        if (en_B) b_mem_r[addr_B[5:0]] <= data_B;
    end

    // Result buffer: a whole output row lands on the last k of that row
    always_ff @(posedge clk) begin
        if (!rst && state_r == COMPUTE && row_end_s) begin
            for (int c = 0; c < 16; c++) begin
                if (5'(c) < cfg_n_r) res_mem_r[res_idx_s[c]] <= acc_next_s[c];
            end
        end
    end

    // Control FSM, instruction register, accumulators and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ap_done   <= 1'b0;
            out_valid <= 1'b0;
            data_O    <= 16'd0;
            inst_r    <= 6'd0;
            cfg_m_r   <= 5'd0;
            cfg_n_r   <= 5'd0;
            cfg_k_r   <= 4'd0;
            row_r     <= 4'd0;
            k_r       <= 3'd0;
            for (int c = 0; c < 16; c++) acc_r[c] <= 16'sd0;
        end else begin
            if (en_I) inst_r <= data_I;
            if (en_O) begin
                if ({1'b0, addr_O} < mn_s) begin
                    data_O    <= res_mem_r[addr_O];
                    out_valid <= 1'b1;
                end else begin
                    data_O    <= 16'd0;
                    out_valid <= 1'b0;
                end
            end
            case (state_r)
                IDLE: begin
                    if (ap_start) begin
                        // Geometry is frozen for the run so mid-run I writes cannot disturb it
                        cfg_m_r <= dim4(inst_r[5:4]);
                        cfg_k_r <= dim2(inst_r[3:2]);
                        cfg_n_r <= dim4(inst_r[1:0]);
                        row_r   <= 4'd0;
                        k_r     <= 3'd0;
                        state_r <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < 16; c++) acc_r[c] <= acc_next_s[c];
                    if (row_end_s) begin
                        k_r <= 3'd0;
                        if (last_row_s) begin
                            state_r <= DONE;
                            ap_done <= 1'b1;
                        end else begin
                            row_r <= row_r + 4'd1;
                        end
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                DONE: begin
                    if (en_O && addr_O == 8'd255) begin
                        state_r <= IDLE;
                        ap_done <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ap_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_top.sv
// Directed bench for top: a behavioural matrix model feeds a scoreboard queue.
// Each result read is popped from that queue and checked with immediate assertions.
module tb_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr_A = 8'd0, addr_B = 8'd0, addr_I = 8'd0, addr_O = 8'd0;
    logic        en_A = 1'b0, en_B = 1'b0, en_I = 1'b0, en_O = 1'b0;
    logic [15:0] data_A = 16'd0, data_B = 16'd0;
    logic [5:0]  data_I = 6'd0;
    logic        ap_start = 1'b0;
    logic [15:0] data_O;
    logic        out_valid;
    logic        ap_done;

    typedef struct {
        int          addr;
        logic [15:0] d;
        logic        v;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] a_w[64];
    logic [15:0] b_w[64];
    logic [5:0]  cur_inst;
    int          n_pass = 0;
    int          n_total = 0;

    top dut (
        .clk(clk), .rst(rst),
        .addr_A(addr_A), .en_A(en_A), .data_A(data_A),
        .addr_B(addr_B), .en_B(en_B), .data_B(data_B),
        .addr_I(addr_I), .en_I(en_I), .data_I(data_I),
        .addr_O(addr_O), .en_O(en_O), .data_O(data_O), .out_valid(out_valid),
        .ap_start(ap_start), .ap_done(ap_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, expv);
    endtask

    function automatic int sb(input logic [15:0] w, input int e);
        logic signed [7:0] v;
        v = (e % 2 == 1) ? w[15:8] : w[7:0];
        return int'(v);
    endfunction

    function automatic exp_t golden(input logic [5:0] ins, input int addr);
        exp_t r;
        int m, k, n, row, col, sum;
        m = 4 * (int'(ins[5:4]) + 1);
        k = 2 * (int'(ins[3:2]) + 1);
        n = 4 * (int'(ins[1:0]) + 1);
        r.addr = addr;
        if (addr < m * n) begin
            row = addr / n;
            col = addr % n;
            sum = 0;
            for (int kk = 0; kk < k; kk++) begin
                sum += sb(a_w[(row * k + kk) / 2], row * k + kk) * sb(b_w[(kk * n + col) / 2], kk * n + col);
            end
            r.d = sum[15:0];
            r.v = 1'b1;
        end else begin
            r.d = 16'd0;
            r.v = 1'b0;
        end
        return r;
    endfunction

    task automatic load_ab(input int i, input logic [15:0] a, input logic [15:0] b);
        a_w[i] = a;
        b_w[i] = b;
        addr_A = 8'(i); data_A = a; en_A = 1'b1;
        addr_B = 8'(i); data_B = b; en_B = 1'b1;
        tick();
        en_A = 1'b0; en_B = 1'b0;
    endtask

    task automatic load_inst(input logic [5:0] ins);
        cur_inst = ins;
        data_I = ins; en_I = 1'b1;
        tick();
        en_I = 1'b0;
    endtask

    task automatic run();
        int cyc;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        cyc = 1;
        while (!ap_done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("done_within_400", cyc, 32'(ap_done), 32'd1);
    endtask

    task automatic read_chk(input int addr);
        exp_t e;
        exp_q.push_back(golden(cur_inst, addr));
        addr_O = 8'(addr); en_O = 1'b1;
        tick();
        en_O = 1'b0;
        e = exp_q.pop_front();
        check("data_O", e.addr, 32'(data_O), 32'(e.d));
        check("out_valid", e.addr, 32'(out_valid), 32'(e.v));
    endtask

    task automatic read_all();
        for (int a = 0; a < 256; a++) begin
            if (a == 255) check("done_before_255", a, 32'(ap_done), 32'd1);
            read_chk(a);
        end
        check("done_falls_at_255", 255, 32'(ap_done), 32'd0);
    endtask

    initial begin
        logic rose;
        cur_inst = 6'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ap_done", 0, 32'(ap_done), 32'd0);
        check("rst_out_valid", 0, 32'(out_valid), 32'd0);
        check("rst_data_O", 0, 32'(data_O), 32'd0);

        // 4x2x4 with ascending A bytes and an identity-like B
        for (int i = 0; i < 64; i++) begin
            load_ab(i, {8'(2 * i + 2), 8'(2 * i + 1)},
                    (i == 0) ? 16'h0001 : ((i == 2) ? 16'h0100 : 16'h0000));
        end
        load_inst(6'b000000);
        run();
        read_all();

        // Largest geometry, every product 1
        for (int i = 0; i < 64; i++) load_ab(i, 16'h0101, 16'h0101);
        load_inst(6'b111111);
        run();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        check("start_ignored_in_done", 0, 32'(ap_done), 32'd1);
        read_all();

        // Signed extremes with K=8: -128*-128 wraps, -1*1 sums negative
        for (int i = 0; i < 64; i++) load_ab(i, 16'h8080, 16'h8080);
        load_inst(6'b001100);
        run();
        read_all();
        for (int i = 0; i < 64; i++) load_ab(i, 16'hFFFF, 16'h0101);
        run();
        read_all();

        // Abort a run with reset, then reissue
        load_inst(6'b111111);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        addr_O = 8'd0; en_O = 1'b1;
        tick();
        en_O = 1'b0;
        check("mid_compute_read", 0, 32'(data_O), 32'h0000FFF8);
        check("mid_compute_valid", 0, 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_inst = 6'd0;
        check("abort_ap_done", 0, 32'(ap_done), 32'd0);
        check("abort_out_valid", 0, 32'(out_valid), 32'd0);
        check("abort_data_O", 0, 32'(data_O), 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ap_done) rose = 1'b1;
        end
        check("no_done_after_abort", 0, 32'(rose), 32'd0);
        read_chk(20);
        load_inst(6'b111111);
        run();
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clock port `clk` and reset port `rst`.
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- addr_A  in  8  A-buffer word address (0..63)
- en_A  in  1  A write enable
- data_A  in  16  A write data
- addr_B  in  8  B-buffer word address (0..63)
- en_B  in  1  B write enable
- data_B  in  16  B write data
- addr_I  in  8  instruction address (informational, ignored)
- en_I  in  1  instruction write enable
- data_I  in  6  instruction
- addr_O  in  8  result address (0..255)
- en_O  in  1  result read enable
- data_O  out  16  result read data
- out_valid  out  1  read data valid for a legal result address
- ap_start  in  1  start request, level
- ap_done  out  1  computation complete / results readable

Function
REQ-003 On each rising edge with en_A=1, the A buffer (64x16) SHALL store data_A at addr_A[5:0]; B buffer identically with en_B/data_B/addr_B.
REQ-004 On each rising edge with en_I=1, the instruction register SHALL capture data_I.
REQ-005 Instruction decode SHALL be:
- M = 4*(inst[5:4]+1), giving 4..16
- K = 2*(inst[3:2]+1), giving 2..8
- N = 4*(inst[1:0]+1), giving 4..16
REQ-006 Operands SHALL be signed 8-bit values packed two per word.
- Element byte index e maps to word e>>1: bits [7:0] for even e, bits [15:8] for odd e.
- A[r][k] SHALL be at e = r*K+k.
- B[k][c] SHALL be at e = k*N+c.
REQ-007 Result O[r][c] SHALL equal the sum over k of A[r][k]*B[k][c], truncated to 16 bits two's complement (wrap, no saturation), stored at result address r*N+c.
REQ-008 The FSM SHALL have states IDLE, COMPUTE and DONE.
- IDLE -> COMPUTE when ap_start=1.
- COMPUTE -> DONE when all M*N results are written; ap_done SHALL then assert.
- DONE -> IDLE on the rising edge that samples en_O=1 with addr_O=255; ap_done SHALL deassert on that same edge.
REQ-009 In DONE, ap_start SHALL be ignored.
REQ-010 ap_done SHALL assert no more than 400 cycles after the start edge.
- Reference datapath: one row of 16 signed 8x8 MAC PEs producing one output row per K accumulate cycles.
REQ-011 Result read latency SHALL be 1 cycle. On a rising edge with en_O=1, the block SHALL register:
- data_O = O[addr_O] and out_valid=1 if addr_O < M*N;
- otherwise data_O=0 and out_valid=0.
- With en_O=0, data_O and out_valid SHALL hold their values.
REQ-012 Reads outside DONE SHALL behave per REQ-011 using the current result buffer contents.
REQ-013 Writes to A, B or I during COMPUTE SHALL be accepted but SHALL NOT be required to affect the running computation.
REQ-014 Every result for a new instruction SHALL overwrite all result addresses below M*N; no stale partial sums are permitted.

Reset
REQ-015 On rst=1 at a rising edge, the block SHALL:
- enter IDLE;
- set ap_done=0, out_valid=0, data_O=0;
- clear the instruction register to 0 and clear the accumulators.
REQ-016 Buffer contents SHALL be unaffected by reset.
REQ-017 Reset mid-COMPUTE SHALL abort the computation; no ap_done SHALL follow until a new ap_start.

Verification
REQ-018 inst=6'b111111, A all 0x0101, B all 0x0101, start -> ap_done within 400 cycles; every O[0..255] = 0x0008 with out_valid=1.
REQ-019 inst=6'b000000 (4x2x4), A words {0x0201,0x0403,...}, B identity-like data -> O[r*4+c] matches the golden products; addresses 16..255 return out_valid=0.
REQ-020 Signed/wrap check: all A bytes 0x80, all B bytes 0x80, K=8 -> each result = 8*16384 mod 65536 = 0x0000; A bytes 0xFF, B bytes 0x01 -> 0xFFF8.
REQ-021 Handshake: after ap_done, read addresses 0..255 sequentially -> ap_done falls on the edge sampling addr_O=255; a second instruction then runs and passes.
REQ-022 Assert rst during COMPUTE -> ap_done=0, out_valid=0, data_O=0 next cycle; a reissued start completes correctly.
